// File: rtl/local_extrema_detector.sv
// local_extrema_detector
//   Streams fixed-length frames of unsigned samples and reports each local
//   maximum (mode=0) or minimum (mode=1). A plateau counts as a single extremum,
//   reported at its first index. When EDGE=1, the first and last samples of a
//   frame may also be extrema.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   en      sample valid; one sample is accepted per clock edge while high
//   in      sample value (DATA_W bits, unsigned)
//   mode    0 = maxima, 1 = minima; latched with the frame's first sample
//   out     one-cycle pulse per detected extremum
//   idx     frame index of the last reported extremum (held while out=0)
//   count   extrema reported so far in the current frame
//   finish  one-cycle pulse the cycle after the frame's last sample
module local_extrema_detector #(
  parameter int DATA_W = 8,
  parameter int LEN    = 32,
  parameter int EDGE   = 0,
  localparam int IDX_W = ($clog2(LEN) < 1) ? 1 : $clog2(LEN),
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] in,
  input  logic              mode,
  output logic              out,
  output logic [IDX_W-1:0]  idx,
  output logic [CNT_W-1:0]  count,
  output logic              finish
);

  typedef enum logic {IDLE, RUN} phase_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  phase_t             phase_q, phase_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [DATA_W-1:0]  prev_q, prev_d;
  logic               climb_q, climb_d;
  logic [IDX_W-1:0]   plat_q, plat_d;
  logic               mode_q, mode_d;
  logic               out_q, out_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               finish_q, finish_d;

  logic is_up, is_down;

  // "up" means moving towards the extremum being searched for.
  always_comb begin
    is_up   = mode_q ? (in < prev_q) : (in > prev_q);
    is_down = (in != prev_q) && !is_up;
  end

  always_comb begin
    phase_d  = phase_q;
    i_d      = i_q;
    prev_d   = prev_q;
    climb_d  = climb_q;
    plat_d   = plat_q;
    mode_d   = mode_q;
    out_d    = 1'b0;
    idx_d    = idx_q;
    count_d  = count_q;
    finish_d = 1'b0;

    if (en) begin
      if (phase_q == IDLE) begin
        // First sample of a frame: nothing to compare against yet.
        phase_d = RUN;
        i_d     = IDX_W'(1);
        prev_d  = in;
        plat_d  = '0;
        climb_d = (EDGE != 0);
        count_d = '0;
        mode_d  = mode;
      end else begin
        prev_d = in;
        if (is_up) begin
          climb_d = 1'b1;
          plat_d  = i_q;
        end else if (is_down && climb_q) begin
          out_d   = 1'b1;
          idx_d   = plat_q;
          count_d = count_q + CNT_W'(1);
          climb_d = 1'b0;
        end
        // Flat samples leave climb/plat untouched so a plateau keeps its start.

        if (i_q == LAST_IDX) begin
          phase_d  = IDLE;
          i_d      = '0;
          finish_d = 1'b1;
          // A still-rising tail ends at the frame boundary. A down-detection
          // on this sample has already cleared climb_d, so only one pulse fires.
          if ((EDGE != 0) && climb_d && !out_d) begin
            out_d   = 1'b1;
            idx_d   = plat_d;
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          i_d = i_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= IDLE;
      i_q      <= '0;
      prev_q   <= '0;
      climb_q  <= 1'b0;
      plat_q   <= '0;
      mode_q   <= 1'b0;
      out_q    <= 1'b0;
      idx_q    <= '0;
      count_q  <= '0;
      finish_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      i_q      <= i_d;
      prev_q   <= prev_d;
      climb_q  <= climb_d;
      plat_q   <= plat_d;
      mode_q   <= mode_d;
      out_q    <= out_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      finish_q <= finish_d;
    end
  end

  assign out    = out_q;
  assign idx    = idx_q;
  assign count  = count_q;
  assign finish = finish_q;

endmodule
